// File: rtl/fp_mant_normalizer.sv
// rtl/fp_mant_normalizer.sv - FP adder mantissa normaliser fed by the leading-one encoder
// Two-stage elastic pipeline: decode/clamp the shift amount, then one-hot shift and exponent adjust.
module fp_mant_normalizer #(
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_mant,
    input  logic [EW-1:0] in_exp,
    input  logic          in_sign,
    input  logic [3:0]    in_pos,
    input  logic          in_nz,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_mant,
    output logic [EW-1:0] out_exp,
    output logic          out_sign,
    output logic          out_zero,
    output logic          out_uflow
);

    logic          s1_valid_q, s1_valid_d;
    logic [15:0]   s1_mant_q,  s1_mant_d;
    logic [EW-1:0] s1_exp_q,   s1_exp_d;
    logic          s1_sign_q,  s1_sign_d;
    logic          s1_nz_q,    s1_nz_d;
    logic          s1_uflow_q, s1_uflow_d;
    logic [15:0]   s1_oh_q,    s1_oh_d;

    logic          s2_valid_q, s2_valid_d;
    logic [15:0]   s2_mant_q,  s2_mant_d;
    logic [EW-1:0] s2_exp_q,   s2_exp_d;
    logic          s2_sign_q,  s2_sign_d;
    logic          s2_zero_q,  s2_zero_d;
    logic          s2_uflow_q, s2_uflow_d;

    logic          s2_adv;
    logic          in_fire;
    logic [3:0]    sh;
    logic [3:0]    sh_eff;
    logic          uflow_dec;
    logic [3:0]    idx;
    logic [15:0]   shifted;

    always_comb begin
        s2_adv   = ~s2_valid_q | out_ready;
        in_ready = ~s1_valid_q | s2_adv;
        in_fire  = in_valid & in_ready;
    end

    // The exponent bounds the shift so a tiny exponent yields a denormal instead of wrapping.
    always_comb begin
        sh = 4'd15 - in_pos;
        if (in_exp <= EW'(sh)) begin
            sh_eff    = in_exp[3:0];
            uflow_dec = 1'b1;
        end else begin
            sh_eff    = sh;
            uflow_dec = 1'b0;
        end
    end

    always_comb begin
        s1_valid_d = in_fire | (s1_valid_q & ~s2_adv);
        s1_mant_d  = s1_mant_q;
        s1_exp_d   = s1_exp_q;
        s1_sign_d  = s1_sign_q;
        s1_nz_d    = s1_nz_q;
        s1_uflow_d = s1_uflow_q;
        s1_oh_d    = s1_oh_q;
        if (in_fire) begin
            s1_mant_d  = in_mant;
            s1_exp_d   = in_exp;
            s1_sign_d  = in_sign;
            s1_nz_d    = in_nz;
            s1_uflow_d = uflow_dec;
            s1_oh_d    = 16'd1 << sh_eff;
        end
    end

    // One-hot select of the shifted copies; idx recovers the amount for the exponent.
    always_comb begin
        idx     = 4'd0;
        shifted = 16'd0;
        for (int i = 0; i < 16; i++) begin
            if (s1_oh_q[i]) begin
                idx     = idx | 4'(i);
                shifted = shifted | (s1_mant_q << i);
            end
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_mant_d  = s2_mant_q;
        s2_exp_d   = s2_exp_q;
        s2_sign_d  = s2_sign_q;
        s2_zero_d  = s2_zero_q;
        s2_uflow_d = s2_uflow_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_d = s1_sign_q;
                if (s1_nz_q) begin
                    s2_mant_d  = shifted;
                    s2_exp_d   = s1_exp_q - EW'(idx);
                    s2_zero_d  = 1'b0;
                    s2_uflow_d = s1_uflow_q;
                end else begin
                    s2_mant_d  = 16'd0;
                    s2_exp_d   = '0;
                    s2_zero_d  = 1'b1;
                    s2_uflow_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mant_q  <= 16'd0;
            s1_exp_q   <= '0;
            s1_sign_q  <= 1'b0;
            s1_nz_q    <= 1'b0;
            s1_uflow_q <= 1'b0;
            s1_oh_q    <= 16'd0;
            s2_valid_q <= 1'b0;
            s2_mant_q  <= 16'd0;
            s2_exp_q   <= '0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_uflow_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mant_q  <= s1_mant_d;
            s1_exp_q   <= s1_exp_d;
            s1_sign_q  <= s1_sign_d;
            s1_nz_q    <= s1_nz_d;
            s1_uflow_q <= s1_uflow_d;
            s1_oh_q    <= s1_oh_d;
            s2_valid_q <= s2_valid_d;
            s2_mant_q  <= s2_mant_d;
            s2_exp_q   <= s2_exp_d;
            s2_sign_q  <= s2_sign_d;
            s2_zero_q  <= s2_zero_d;
            s2_uflow_q <= s2_uflow_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_mant  = s2_mant_q;
    assign out_exp   = s2_exp_q;
    assign out_sign  = s2_sign_q;
    assign out_zero  = s2_zero_q;
    assign out_uflow = s2_uflow_q;

endmodule

// File: tb/tb_fp_mant_normalizer.sv
// tb/tb_fp_mant_normalizer.sv - self-checking bench for fp_mant_normalizer
// Vector table plus random stall and reset sequences, checked through an expected-result queue.
module tb_fp_mant_normalizer;

    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   in_mant = 16'd0;
    logic [EW-1:0] in_exp = '0;
    logic          in_sign = 1'b0;
    logic [3:0]    in_pos = 4'd0;
    logic          in_nz = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [15:0]   out_mant;
    logic [EW-1:0] out_exp;
    logic          out_sign;
    logic          out_zero;
    logic          out_uflow;

    fp_mant_normalizer #(.EW(EW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mant(in_mant), .in_exp(in_exp), .in_sign(in_sign),
        .in_pos(in_pos), .in_nz(in_nz),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mant(out_mant), .out_exp(out_exp), .out_sign(out_sign),
        .out_zero(out_zero), .out_uflow(out_uflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]   mant;
        logic [EW-1:0] exp;
        logic          sign;
        logic          zero;
        logic          uflow;
        int            ld_edge;
    } res_t;

    typedef struct {
        logic [15:0]   mant;
        logic [EW-1:0] exp;
        logic          sign;
        logic [3:0]    pos;
        logic          nz;
        logic [15:0]   e_mant;
        logic [EW-1:0] e_exp;
        logic          e_zero;
        logic          e_uflow;
    } vec_t;

    res_t q[$];
    vec_t vecs[11];
    int   errors = 0;
    int   checks = 0;
    int   edge_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic res_t model(input logic [15:0] m, input logic [EW-1:0] e,
                                   input logic s, input logic [3:0] p, input logic nz);
        res_t r;
        int   shv;
        int   amt;
        r.sign = s;
        r.ld_edge = 0;
        if (!nz) begin
            r.mant = 16'd0; r.exp = '0; r.zero = 1'b1; r.uflow = 1'b0;
        end else begin
            shv = 15 - int'(p);
            if (int'(e) <= shv) begin
                amt = int'(e); r.uflow = 1'b1;
            end else begin
                amt = shv; r.uflow = 1'b0;
            end
            r.mant = m << amt;
            r.exp  = e - EW'(amt);
            r.zero = 1'b0;
        end
        return r;
    endfunction

    // Inputs are already applied; check, then take one clock edge.
    task automatic cycle(input res_t push_exp);
        logic        stalled;
        logic [15:0] h_mant;
        logic [EW-1:0] h_exp;
        logic [2:0]  h_flags;
        res_t        r;
        #1;
        chk("out_valid_timing", {31'd0, out_valid},
            {31'd0, (q.size() > 0) && (q[0].ld_edge < edge_cnt)});
        chk("in_ready", {31'd0, in_ready}, {31'd0, !(q.size() == 2 && !out_ready)});
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_output", 32'd1, 32'd0);
            end else begin
                r = q.pop_front();
                chk("mant",  {16'd0, out_mant}, {16'd0, r.mant});
                chk("exp",   {24'd0, out_exp},  {24'd0, r.exp});
                chk("sign",  {31'd0, out_sign}, {31'd0, r.sign});
                chk("zero",  {31'd0, out_zero}, {31'd0, r.zero});
                chk("uflow", {31'd0, out_uflow}, {31'd0, r.uflow});
            end
        end
        if (in_valid && in_ready) begin
            r = push_exp;
            r.ld_edge = edge_cnt + 1;
            q.push_back(r);
        end
        stalled = out_valid && !out_ready;
        h_mant  = out_mant;
        h_exp   = out_exp;
        h_flags = {out_sign, out_zero, out_uflow};
        @(posedge clk);
        edge_cnt++;
        #1;
        if (stalled) begin
            chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_hold_data", {out_mant, out_exp, 5'd0, out_sign, out_zero, out_uflow},
                {h_mant, h_exp, 5'd0, h_flags});
        end
    endtask

    task automatic drive(input logic [15:0] m, input logic [EW-1:0] e, input logic s,
                         input logic [3:0] p, input logic nz);
        in_valid = 1'b1; in_mant = m; in_exp = e; in_sign = s; in_pos = p; in_nz = nz;
    endtask

    task automatic drain(input int budget);
        res_t dummy;
        int   n;
        dummy = model(16'd0, '0, 1'b0, 4'd0, 1'b0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < budget) begin
            cycle(dummy);
            n++;
        end
        chk("drain_timeout", q.size(), 32'd0);
        q.delete();
    endtask

    initial begin
        res_t  e;
        res_t  beats[8];
        int    sent;
        int    cyc;
        logic [3:0] rdy_pat;

        vecs[0]  = '{16'h0001, 8'd20,  1'b0, 4'd0,  1'b1, 16'h8000, 8'd5,   1'b0, 1'b0};
        vecs[1]  = '{16'h8123, 8'd7,   1'b0, 4'd15, 1'b1, 16'h8123, 8'd7,   1'b0, 1'b0};
        vecs[2]  = '{16'h0010, 8'd5,   1'b0, 4'd4,  1'b1, 16'h0200, 8'd0,   1'b0, 1'b1};
        vecs[3]  = '{16'h0000, 8'd99,  1'b0, 4'd0,  1'b0, 16'h0000, 8'd0,   1'b1, 1'b0};
        vecs[4]  = '{16'h0100, 8'd7,   1'b0, 4'd8,  1'b1, 16'h8000, 8'd0,   1'b0, 1'b1};
        vecs[5]  = '{16'h0100, 8'd8,   1'b0, 4'd8,  1'b1, 16'h8000, 8'd1,   1'b0, 1'b0};
        vecs[6]  = '{16'h0001, 8'd0,   1'b0, 4'd0,  1'b1, 16'h0001, 8'd0,   1'b0, 1'b1};
        vecs[7]  = '{16'h0003, 8'd100, 1'b0, 4'd2,  1'b1, 16'h6000, 8'd87,  1'b0, 1'b0};
        vecs[8]  = '{16'h1234, 8'd255, 1'b1, 4'd12, 1'b1, 16'h91A0, 8'd252, 1'b0, 1'b0};
        vecs[9]  = '{16'h0000, 8'd3,   1'b1, 4'd5,  1'b0, 16'h0000, 8'd0,   1'b1, 1'b0};
        vecs[10] = '{16'h0001, 8'd255, 1'b0, 4'd0,  1'b1, 16'h8000, 8'd240, 1'b0, 1'b0};

        #12;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_data", {out_mant, out_exp, 5'd0, out_sign, out_zero, out_uflow}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table vectors back-to-back with the sink always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].mant, vecs[i].exp, vecs[i].sign, vecs[i].pos, vecs[i].nz);
            e.mant = vecs[i].e_mant; e.exp = vecs[i].e_exp; e.sign = vecs[i].sign;
            e.zero = vecs[i].e_zero; e.uflow = vecs[i].e_uflow; e.ld_edge = 0;
            cycle(e);
        end
        drain(20);

        // Eight random beats against a 1,0,0,1 ready pattern.
        for (int i = 0; i < 8; i++) begin
            beats[i].mant = 16'($urandom);
            beats[i].exp  = EW'($urandom_range(0, 30));
            beats[i].sign = 1'($urandom);
            beats[i].uflow = 1'($urandom_range(0, 7) != 0);
        end
        rdy_pat = 4'b1001;
        sent = 0;
        cyc = 0;
        while (sent < 8 && cyc < 200) begin
            out_ready = rdy_pat[cyc % 4];
            drive(beats[sent].mant, beats[sent].exp, beats[sent].sign,
                  4'(beats[sent].mant >> 12), beats[sent].uflow);
            e = model(in_mant, in_exp, in_sign, in_pos, in_nz);
            #1;
            if (in_ready) begin
                #0;
                cycle(e);
                sent++;
            end else begin
                cycle(e);
            end
            cyc++;
        end
        chk("stream_sent", sent, 32'd8);
        drain(60);

        // Reset with two beats in flight, then one fresh beat.
        out_ready = 1'b0;
        drive(16'h0001, 8'd20, 1'b0, 4'd0, 1'b1);
        cycle(model(16'h0001, 8'd20, 1'b0, 4'd0, 1'b1));
        drive(16'h0010, 8'd5, 1'b0, 4'd4, 1'b1);
        cycle(model(16'h0010, 8'd5, 1'b0, 4'd4, 1'b1));
        in_valid = 1'b0;
        chk("inflight_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", {31'd0, out_valid}, 32'd0);
        chk("async_reset_data", {out_mant, out_exp, 8'd0}, 32'd0);
        q.delete();
        @(posedge clk); edge_cnt++;
        @(posedge clk); edge_cnt++;
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(16'h8123, 8'd7, 1'b1, 4'd15, 1'b1);
        cycle(model(16'h8123, 8'd7, 1'b1, 4'd15, 1'b1));
        in_valid = 1'b0;
        drain(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
